seg_pipe_approx_adder: RTL and testbench

- Parametrised, pipelined successor to the single-bit full adder cell.
- Adds two WIDTH-bit operands plus carry-in, one SEG_W-bit segment per pipeline stage, with the carry registered between stages.
- Selectable per-transaction mode: exact, lower-part-OR (LOA) approximate, or truncated approximate.
- Serves as the configurable adder core for accuracy/area experiments; valid/ready on both sides.

---
 rtl/adder_pkg.sv | 69 ++++++
 rtl/seg_adder_stage.sv | 79 +++++++
 rtl/seg_pipe_approx_adder.sv | 159 +++++++++++++++
 tb/tb_seg_pipe_approx_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined approximate adder:
// mode encodings, a one-bit full adder cell and an arithmetic reference model.
package adder_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_LOA   = 2'b01;
  localparam logic [1:0] MODE_TRUNC = 2'b10;

  localparam int REF_MAX_W = 64;

  typedef logic [REF_MAX_W-1:0] ref_word_t;

  typedef enum logic [1:0] {
    ADD_EXACT = 2'b00,
    ADD_LOA   = 2'b01,
    ADD_TRUNC = 2'b10,
    ADD_ALIAS = 2'b11
  } add_mode_e;

  // Mode 11 is an alias of exact; only LOA and truncate approximate.
  function automatic logic mode_is_approx(input logic [1:0] m);
    return (m == MODE_LOA) || (m == MODE_TRUNC);
  endfunction

  // Returns {carry_out, sum} of a single full adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Word-level reference result {cout, sum}; width must be below REF_MAX_W.
  function automatic logic [REF_MAX_W:0] ref_add(
    input ref_word_t  a,
    input ref_word_t  b,
    input logic       cin,
    input logic [1:0] mode,
    input int         width,
    input int         k
  );
    ref_word_t        wmask;
    ref_word_t        lmask;
    ref_word_t        hi_a;
    ref_word_t        hi_b;
    ref_word_t        lo;
    ref_word_t        s;
    logic [REF_MAX_W:0] total;
    logic             c;
    int               kk;

    kk = mode_is_approx(mode) ? k : 0;
    wmask = (ref_word_t'(1) << width) - ref_word_t'(1);
    lmask = (ref_word_t'(1) << kk) - ref_word_t'(1);
    hi_a = (a & wmask) >> kk;
    hi_b = (b & wmask) >> kk;

    if (mode == MODE_TRUNC) begin
      c = 1'b0;
    end else if (mode == MODE_LOA) begin
      c = (k > 0 && k < width) ? (a[k-1] & b[k-1]) : 1'b0;
    end else begin
      c = cin;
    end

    total = {1'b0, hi_a} + {1'b0, hi_b} + {{REF_MAX_W{1'b0}}, c};
    lo = (mode == MODE_LOA) ? ((a | b) & lmask) : '0;
    s = ((total[REF_MAX_W-1:0] << kk) | lo) & wmask;
    return {total[width-kk], s};
  endfunction

endpackage

// File: rtl/seg_adder_stage.sv
// One pipeline stage: SEG_W-bit ripple of full adder cells with registered
// sum segment, carry, valid and mode, all held while the pipeline is stalled.
module seg_adder_stage
  import adder_pkg::*;
#(
  parameter int SEG_W       = 4,
  parameter int SEG_IDX     = 0,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [1:0]       mode_in,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             carry_in,
  output logic             valid_q,
  output logic [1:0]       mode_q,
  output logic             carry_q,
  output logic [SEG_W-1:0] sum_q
);

  logic             valid_d;
  logic [1:0]       mode_d;
  logic             carry_d;
  logic [SEG_W-1:0] sum_d;

  logic             approx;
  logic             chain_c;
  logic [1:0]       fa_out;
  logic [SEG_W-1:0] seg_sum;

  // Approximated bit positions pass the carry straight through, so an injected
  // carry lands on the first exact bit wherever K falls inside the word.
  always_comb begin
    approx  = mode_is_approx(mode_in);
    chain_c = carry_in;
    fa_out  = '0;
    seg_sum = '0;
    for (int j = 0; j < SEG_W; j++) begin
      if (approx && (SEG_IDX * SEG_W + j < APPROX_BITS)) begin
        seg_sum[j] = (mode_in == MODE_LOA) & (a_seg[j] | b_seg[j]);
      end else begin
        fa_out     = full_add(a_seg[j], b_seg[j], chain_c);
        seg_sum[j] = fa_out[0];
        chain_c    = fa_out[1];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    if (en) begin
      valid_d = valid_in;
      mode_d  = mode_in;
      carry_d = chain_c;
      sum_d   = seg_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/seg_pipe_approx_adder.sv
// Pipelined WIDTH-bit adder, one SEG_W segment per stage, with exact, LOA and
// truncated modes chosen per transaction; valid/ready handshake on both sides.
module seg_pipe_approx_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SEG_W       = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSEG     = WIDTH / SEG_W;
  localparam int CINJ_BIT = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

  logic             en;
  logic             c_inj;
  logic             chain_cin;
  logic             stage_valid [NSEG];
  logic             stage_carry [NSEG];
  logic [1:0]       stage_mode  [NSEG];
  logic [SEG_W-1:0] seg_sum     [NSEG];
  logic [SEG_W-1:0] sum_aligned [NSEG];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    c_inj = 1'b0;
    if (APPROX_BITS > 0) begin
      c_inj = a[CINJ_BIT] & b[CINJ_BIT];
    end
    case (mode)
      MODE_LOA:   chain_cin = c_inj;
      MODE_TRUNC: chain_cin = 1'b0;
      default:    chain_cin = cin;
    endcase
  end

  generate
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
      localparam int DLY = NSEG - 1 - i;

      logic [SEG_W-1:0] a_in;
      logic [SEG_W-1:0] b_in;
      logic             carry_in;
      logic             valid_in;
      logic [1:0]       mode_in;

      if (i == 0) begin : g_head
        assign a_in     = a[SEG_W-1:0];
        assign b_in     = b[SEG_W-1:0];
        assign carry_in = chain_cin;
        assign valid_in = in_valid;
        assign mode_in  = mode;
      end else begin : g_skew
        // Segment i of the operands waits i cycles to meet its incoming carry.
        logic [2*SEG_W-1:0] skew_d [i];
        logic [2*SEG_W-1:0] skew_q [i];

        always_comb begin
          skew_d[0] = en ? {a[i*SEG_W +: SEG_W], b[i*SEG_W +: SEG_W]} : skew_q[0];
          for (int k = 1; k < i; k++) begin
            skew_d[k] = en ? skew_q[k-1] : skew_q[k];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < i; k++) begin
              skew_q[k] <= '0;
            end
          end else begin
            for (int k = 0; k < i; k++) begin
              skew_q[k] <= skew_d[k];
            end
          end
        end

        assign a_in     = skew_q[i-1][2*SEG_W-1:SEG_W];
        assign b_in     = skew_q[i-1][SEG_W-1:0];
        assign carry_in = stage_carry[i-1];
        assign valid_in = stage_valid[i-1];
        assign mode_in  = stage_mode[i-1];
      end

      seg_adder_stage #(
        .SEG_W       (SEG_W),
        .SEG_IDX     (i),
        .APPROX_BITS (APPROX_BITS)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .valid_in (valid_in),
        .mode_in  (mode_in),
        .a_seg    (a_in),
        .b_seg    (b_in),
        .carry_in (carry_in),
        .valid_q  (stage_valid[i]),
        .mode_q   (stage_mode[i]),
        .carry_q  (stage_carry[i]),
        .sum_q    (seg_sum[i])
      );

      if (DLY == 0) begin : g_tail
        assign sum_aligned[i] = seg_sum[i];
      end else begin : g_deskew
        logic [SEG_W-1:0] dsk_d [DLY];
        logic [SEG_W-1:0] dsk_q [DLY];

        always_comb begin
          dsk_d[0] = en ? seg_sum[i] : dsk_q[0];
          for (int k = 1; k < DLY; k++) begin
            dsk_d[k] = en ? dsk_q[k-1] : dsk_q[k];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < DLY; k++) begin
              dsk_q[k] <= '0;
            end
          end else begin
            for (int k = 0; k < DLY; k++) begin
              dsk_q[k] <= dsk_d[k];
            end
          end
        end

        assign sum_aligned[i] = dsk_q[DLY-1];
      end
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < NSEG; i++) begin
      sum[i*SEG_W +: SEG_W] = sum_aligned[i];
    end
  end

  // With every bit approximated the upper part is empty, so no carry may leave.
  assign out_valid = stage_valid[NSEG-1];
  assign cout      = stage_carry[NSEG-1] &
                     !((APPROX_BITS >= WIDTH) && mode_is_approx(stage_mode[NSEG-1]));

endmodule

// File: tb/tb_seg_pipe_approx_adder.sv
// Scoreboard bench for seg_pipe_approx_adder: directed vectors, streaming with
// backpressure, bubble propagation and mid-flight reset.
module tb_seg_pipe_approx_adder;
  import adder_pkg::*;

  localparam int WIDTH       = 16;
  localparam int SEG_W       = 4;
  localparam int APPROX_BITS = 4;
  localparam int NSEG        = WIDTH / SEG_W;

  typedef logic [WIDTH:0] result_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  result_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      pushed = 0;
  int      popped = 0;
  int      lat;
  bit      seen;
  result_t held;
  logic    ov [8];

  always #5 clk = ~clk;

  seg_pipe_approx_adder #(
    .WIDTH       (WIDTH),
    .SEG_W       (SEG_W),
    .APPROX_BITS (APPROX_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic result_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                    input logic c, input logic [1:0] m);
    logic [REF_MAX_W:0] r;
    r = ref_add(ref_word_t'(av), ref_word_t'(bv), c, m, WIDTH, APPROX_BITS);
    return {r[REF_MAX_W], r[WIDTH-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one word from just after a rising edge and holds it until accepted.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic c, input logic [1:0] m, input result_t exp_res);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = c;
    mode     = m;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        exp_q.push_back(exp_res);
        pushed++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("accepted", 32'(accepted), 32'(1));
  endtask

  task automatic applyRandom();
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             c;
    logic [1:0]       m;
    av = WIDTH'($urandom);
    bv = WIDTH'($urandom);
    c  = 1'($urandom);
    m  = 2'($urandom_range(0, 3));
    applyStimulus(av, bv, c, m, model(av, bv, c, m));
  endtask

  task automatic monitorLoop();
    result_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        popped++;
        checkOutput($sformatf("output_expected%0d", popped), 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput($sformatf("result%0d", popped), 32'({cout, sum}), 32'(e));
        end
      end
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'(0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts rising edges from the accepting edge until out_valid is seen.
  task automatic measureLatency(input string tag);
    lat  = 1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    checkOutput(tag, 32'(lat), 32'(NSEG));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    mode      = MODE_EXACT;
    out_ready = 1'b1;
    fork
      monitorLoop();
    join_none

    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_sum", 32'(sum), 32'(0));
    checkOutput("rst_cout", 32'(cout), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_idle_valid", 32'(out_valid), 32'(0));

    $display("[TB] directed vectors");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, MODE_EXACT, 17'h1_0000);
    in_valid = 1'b0;
    measureLatency("latency_exact");

    applyStimulus(16'h1234, 16'h1111, 1'b1, 2'b11,      17'h0_2346);
    applyStimulus(16'h000F, 16'h0001, 1'b0, MODE_LOA,   17'h0_000F);
    applyStimulus(16'h0008, 16'h0008, 1'b0, MODE_LOA,   17'h0_0018);
    applyStimulus(16'hFFF0, 16'h0018, 1'b1, MODE_LOA,   17'h1_0008);
    applyStimulus(16'h1234, 16'h0FFF, 1'b1, MODE_TRUNC, 17'h0_2220);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] streaming with backpressure");
    pushed = 0;
    popped = 0;
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          applyRandom();
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = {cout, sum};
        checkOutput("stall_valid", 32'(out_valid), 32'(1));
        checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
        repeat (2) begin
          @(negedge clk);
          checkOutput("stall_hold", 32'({cout, sum}), 32'(held));
          checkOutput("stall_valid_hold", 32'(out_valid), 32'(1));
          checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stream_count", 32'(popped), 32'(8));

    $display("[TB] bubbles");
    for (int k = 0; k < 8; k++) begin
      in_valid = ((k < 4) && (k % 2 == 0)) ? 1'b1 : 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
      mode     = 2'($urandom_range(0, 3));
      @(negedge clk);
      ov[k] = out_valid;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, mode));
        pushed++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("bubble_ov%0d", k), 32'(ov[k]),
                  32'(((k >= NSEG) && (k % 2 == 0)) ? 1 : 0));
    end
    waitDrain();

    $display("[TB] reset with words in flight");
    for (int w = 0; w < 3; w++) begin
      applyRandom();
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'(0));
    checkOutput("async_rst_sum", 32'(sum), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h0F0F, 16'h00F1, 1'b1, MODE_EXACT, 17'h0_1001);
    in_valid = 1'b0;
    measureLatency("latency_after_reset");
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
